// File: rtl/sev_led_pkg.sv
// Shared constants, FSM state type and segment-pattern decode for the
// seven-segment reader.
package sev_led_pkg;

  localparam logic [6:0] SEG_D0    = 7'h7E;
  localparam logic [6:0] SEG_D1    = 7'h10;
  localparam logic [6:0] SEG_D2    = 7'h0F;
  localparam logic [6:0] SEG_D3    = 7'h55;
  localparam logic [6:0] SEG_D4    = 7'h3A;
  localparam logic [6:0] SEG_D5    = 7'h61;
  localparam logic [6:0] SEG_D6    = 7'h2D;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_e;

  // Returns {hit, code}; hit is 0 for blank and for unknown patterns.
  function automatic logic [4:0] seg_to_code(input logic [6:0] seg);
    case (seg)
      SEG_D0:  return {1'b1, 4'd0};
      SEG_D1:  return {1'b1, 4'd1};
      SEG_D2:  return {1'b1, 4'd2};
      SEG_D3:  return {1'b1, 4'd3};
      SEG_D4:  return {1'b1, 4'd4};
      SEG_D5:  return {1'b1, 4'd5};
      SEG_D6:  return {1'b1, 4'd6};
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/sev_led_sync.sv
// Two-flop synchroniser for a bus of independent, slowly changing lines.
module sev_led_sync #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= i_d;
      s2_q <= s1_q;
    end
  end

  assign o_q = s2_q;

endmodule

// File: rtl/sev_led_reader.sv
// Resynchronises a raw segment pattern, waits for it to hold stable, then
// decodes it back to a digit code with valid/error/blank reporting.
module sev_led_reader
  import sev_led_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_blank,
  output logic       o_locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       s2;
  logic [6:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  state_e           state_q, state_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             blank_q, blank_d;
  logic             same;
  logic [4:0]       dec;

  sev_led_sync #(.W(7)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_seg),
    .o_q     (s2)
  );

  always_comb begin
    same    = (s2 == prev_q);
    cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    dec     = seg_to_code(s2);
    prev_d  = s2;
    cnt_d   = cnt_q;
    state_d = state_q;
    code_d  = code_q;
    blank_d = blank_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    // Disable wins over everything, including an acceptance this cycle.
    if (!i_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = TRACK;
          cnt_d   = '0;
        end
        TRACK: begin
          if (!same) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = LOCKED;
              if (dec[4]) begin
                code_d  = dec[3:0];
                valid_d = 1'b1;
                blank_d = 1'b0;
              end else if (s2 == SEG_BLANK) begin
                blank_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          if (!same) begin
            state_d = TRACK;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      blank_q <= blank_d;
    end
  end

  assign o_code   = code_q;
  assign o_valid  = valid_q;
  assign o_err    = err_q;
  assign o_blank  = blank_q;
  assign o_locked = (state_q == LOCKED);

endmodule

// File: tb/tb_sev_led_reader.sv
// Directed bench for sev_led_reader: table of held patterns plus hand-written
// step, glitch, enable-drop and asynchronous-reset sequences.
module tb_sev_led_reader;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_enable;
  logic [6:0] i_seg;
  logic [3:0] o_code;
  logic       o_valid, o_err, o_blank, o_locked;

  int tests = 0;
  int fails = 0;

  int v_cnt, v_edge, v_code, e_cnt, e_edge, both;
  int code_at[64];
  int locked_at[64];

  typedef struct {
    logic [6:0] seg;
    int n;
    int vcnt;
    int vedge;
    int vcode;
    int ecnt;
    int eedge;
    int code;
    int blank;
    int locked;
  } vec_t;

  vec_t tbl[8];

  sev_led_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
    .i_seg    (i_seg),
    .o_code   (o_code),
    .o_valid  (o_valid),
    .o_err    (o_err),
    .o_blank  (o_blank),
    .o_locked (o_locked)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Observe n rising edges; edge 1 is the first edge after the call.
  task automatic watch(input int n);
    v_cnt = 0; v_edge = 0; v_code = 0; e_cnt = 0; e_edge = 0; both = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge i_clk);
      #1;
      code_at[k]   = int'(o_code);
      locked_at[k] = int'(o_locked);
      if (o_valid === 1'b1) begin
        v_cnt++;
        if (v_edge == 0) begin
          v_edge = k;
          v_code = int'(o_code);
        end
      end
      if (o_err === 1'b1) begin
        e_cnt++;
        if (e_edge == 0) e_edge = k;
      end
      if (o_valid === 1'b1 && o_err === 1'b1) both++;
    end
  endtask

  task automatic apply(input logic [6:0] seg, input int n);
    @(negedge i_clk);
    i_seg = seg;
    watch(n);
  endtask

  initial begin
    tbl[0] = '{7'h7F, 12, 0, 0, 0, 1, 6, 6, 0, 1};
    tbl[1] = '{7'h00, 12, 0, 0, 0, 0, 0, 6, 1, 1};
    tbl[2] = '{7'h3A, 12, 1, 6, 4, 0, 0, 4, 0, 1};
    tbl[3] = '{7'h61, 12, 1, 6, 5, 0, 0, 5, 0, 1};
    tbl[4] = '{7'h10, 12, 1, 6, 1, 0, 0, 1, 0, 1};
    tbl[5] = '{7'h0F, 12, 1, 6, 2, 0, 0, 2, 0, 1};
    tbl[6] = '{7'h55, 12, 1, 6, 3, 0, 0, 3, 0, 1};
    tbl[7] = '{7'h7E, 12, 1, 6, 0, 0, 0, 0, 0, 1};

    i_rst_n  = 1'b0;
    i_enable = 1'b1;
    i_seg    = 7'h00;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_code",   int'(o_code),   0);
    chk("rst_valid",  int'(o_valid),  0);
    chk("rst_err",    int'(o_err),    0);
    chk("rst_blank",  int'(o_blank),  0);
    chk("rst_locked", int'(o_locked), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // First acceptance out of reset, then a long quiet hold.
    apply(7'h55, 50);
    chk("first_vcnt",   v_cnt,           1);
    chk("first_vedge",  v_edge,          6);
    chk("first_vcode",  v_code,          3);
    chk("first_ecnt",   e_cnt,           0);
    chk("first_locked", int'(o_locked),  1);

    // Step to another digit: lock drops, old code holds until new pulse.
    apply(7'h2D, 12);
    chk("step_unlock",  locked_at[3], 0);
    chk("step_hold",    code_at[5],   3);
    chk("step_vcnt",    v_cnt,        1);
    chk("step_vedge",   v_edge,       6);
    chk("step_vcode",   v_code,       6);
    chk("step_relock",  locked_at[6], 1);

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].seg, tbl[i].n);
      chk($sformatf("tbl%0d_vcnt", i),   v_cnt,           tbl[i].vcnt);
      chk($sformatf("tbl%0d_vedge", i),  v_edge,          tbl[i].vedge);
      chk($sformatf("tbl%0d_vcode", i),  v_code,          tbl[i].vcode);
      chk($sformatf("tbl%0d_ecnt", i),   e_cnt,           tbl[i].ecnt);
      chk($sformatf("tbl%0d_eedge", i),  e_edge,          tbl[i].eedge);
      chk($sformatf("tbl%0d_both", i),   both,            0);
      chk($sformatf("tbl%0d_code", i),   int'(o_code),    tbl[i].code);
      chk($sformatf("tbl%0d_blank", i),  int'(o_blank),   tbl[i].blank);
      chk($sformatf("tbl%0d_locked", i), int'(o_locked),  tbl[i].locked);
    end

    // Two-cycle glitch to 7'h10 while 7'h7E is locked.
    apply(7'h10, 2);
    chk("glitch_vcnt", v_cnt, 0);
    chk("glitch_code", code_at[2], 0);
    apply(7'h7E, 12);
    chk("reacc_vcnt",  v_cnt,  1);
    chk("reacc_vcode", v_code, 0);
    chk("reacc_vedge", v_edge, 6);

    // Enable dropped on the cycle that would accept 7'h3A.
    apply(7'h3A, 5);
    chk("en_pre_vcnt", v_cnt, 0);
    @(negedge i_clk);
    i_enable = 1'b0;
    @(posedge i_clk);
    #1;
    chk("en_drop_valid",  int'(o_valid),  0);
    chk("en_drop_locked", int'(o_locked), 0);
    chk("en_drop_code",   int'(o_code),   0);
    watch(3);
    chk("en_idle_vcnt", v_cnt, 0);
    @(negedge i_clk);
    i_enable = 1'b1;
    watch(10);
    chk("reen_vcnt",  v_cnt,  1);
    chk("reen_vedge", v_edge, 4);
    chk("reen_vcode", v_code, 4);

    // Asynchronous reset between edges while tracking a new pattern.
    apply(7'h55, 4);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_code",   int'(o_code),   0);
    chk("arst_locked", int'(o_locked), 0);
    chk("arst_blank",  int'(o_blank),  0);
    chk("arst_valid",  int'(o_valid),  0);
    chk("arst_err",    int'(o_err),    0);
    @(negedge i_clk);
    i_seg = 7'h61;
    #1;
    i_rst_n = 1'b1;
    watch(12);
    chk("post_rst_vcnt",  v_cnt,  1);
    chk("post_rst_vedge", v_edge, 6);
    chk("post_rst_vcode", v_code, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sev_led_reader.md
Name: sev_led_reader

Overview:
Inverse of the seven-segment encoding used in this codebase. It samples a 7-bit segment pattern, which may come from an asynchronous source such as a display tap or a loopback of the encoder's segment lines, and resynchronises it. It qualifies the pattern by requiring it to hold stable for a programmable number of cycles, then decodes it back to a 4-bit digit code. Sits between external segment lines and the control/self-test logic that checks what the display is showing.

Parameters:
STABLE_CYCLES, 4, consecutive identical synchronised samples required before a pattern is accepted; legal range 1..255.
CNT_W, 8, width of stability counter; must satisfy 2**CNT_W > STABLE_CYCLES.

Ports:
i_clk  in  1  system clock, rising-edge.
i_rst_n  in  1  reset, asynchronous assert, active-low.
i_enable  in  1  tracking enable; low parks the block in IDLE.
i_seg  in  7  raw segment pattern, asynchronous to i_clk, bit 0 = segment line 1.
o_code  out  4  last accepted digit code, 0..6.
o_valid  out  1  one-cycle pulse: new valid code accepted, o_code updated same cycle.
o_err  out  1  one-cycle pulse: stable pattern not in code table and not blank.
o_blank  out  1  level: last accepted stable pattern was 7'h00.
o_locked  out  1  level: state is LOCKED.

Behaviour:
- Clock and reset: one clock i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: sync flops 0, prev 0, counter 0, state IDLE, o_code 0, o_valid 0, o_err 0, o_blank 0, o_locked 0.
- Synchroniser: i_seg passes through 2 flops (s1, s2); all logic uses s2 only.
- Code table, fixed:
  - 7'h7E->0, 7'h10->1, 7'h0F->2, 7'h55->3.
  - 7'h3A->4, 7'h61->5, 7'h2D->6.
  - 7'h00 = blank; any other value = error.
- prev register: holds s2 from the previous cycle.
- States IDLE, TRACK, LOCKED:
  - IDLE: counter held 0, pulses 0, o_code and o_blank hold. i_enable=1 -> TRACK with counter 0.
  - TRACK, s2!=prev: counter <= 0, stay TRACK.
  - TRACK, s2==prev: counter increments.
  - TRACK, s2==prev and counter==STABLE_CYCLES-1: accept the pattern and go to LOCKED.
  - LOCKED, s2==prev: no further pulses.
  - LOCKED, s2!=prev: -> TRACK with counter 0. o_code and o_blank hold until the next acceptance.
  - Any state, i_enable=0: -> IDLE next edge, overriding acceptance in that same cycle.
- Acceptance, registered, on the same edge as the transition into LOCKED:
  - Table hit: o_code <= decoded value, o_valid=1 for exactly one cycle, o_blank <= 0.
  - Blank: o_blank <= 1, o_code holds, no pulse.
  - Other: o_err=1 for one cycle, o_code and o_blank hold.
  - o_valid and o_err are never high together.
- Latency: if i_seg changes and then holds, o_valid/o_err asserts on edge STABLE_CYCLES+2, counting from edge 1 = first edge sampling the new value into s1. With the default this is edge 6.
- Glitches: a change shorter than the stability window restarts the counter. The previously accepted output is kept; no pulse is generated.
- Same pattern returns after a glitch: it is re-accepted and re-pulses o_valid. The downstream consumer tolerates duplicates.
- Counter: saturates at STABLE_CYCLES-1 and never wraps.
- Reset mid-operation: immediate return to reset values. Any in-flight pulse is dropped.

Decomposition:
- Package sev_led_pkg:
  - constants SEG_D0..SEG_D6 (7'h7E, 7'h10, 7'h0F, 7'h55, 7'h3A, 7'h61, 7'h2D) and SEG_BLANK=7'h00.
  - state enum IDLE/TRACK/LOCKED.
  - function seg_to_code returning {hit, code[3:0]}.
- One sub-module, sev_led_sync: parameterised-width 2-flop synchroniser with async active-low reset.

Test Plan:
- Reset, enable=1, i_seg=7'h55 held -> o_valid single pulse at edge 6 with o_code=3, o_locked=1, no further pulses over 50 cycles.
- Step 7'h55 -> 7'h2D held -> o_locked drops, o_code stays 3 until the o_valid pulse with o_code=6, 6 edges after the change.
- 7'h7E held, then a 2-cycle glitch to 7'h10, then back to 7'h7E -> no pulse with o_code=1. Exactly one re-accept pulse with o_code=0 follows after the glitch.
- i_seg=7'h7F held -> one o_err pulse, o_valid never asserts, o_code unchanged. Then i_seg=7'h00 -> o_blank=1, no pulse.
- i_enable dropped on the acceptance cycle with 7'h3A stable -> no o_valid pulse, state IDLE. Re-enable -> pulse with o_code=4 at STABLE_CYCLES edges later.
- i_rst_n asserted asynchronously mid-TRACK, between clock edges -> all outputs 0 immediately. After release, with i_seg=7'h61 held -> pulse with o_code=5 at edge 6.
